// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: mode encodings and master state type shared by the SPI memory bridge
package spi_mem_pkg;
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_HOST = 2'b01;
  localparam logic [1:0] MODE_MASTER = 2'b10;
  localparam logic [1:0] MODE_SLAVE = 2'b11;
  typedef enum logic [2:0] {M_IDLE, M_LOAD, M_LOW, M_HIGH, M_STORE, M_END} m_state_t;
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-FF synchroniser with one-cycle rise/fall pulses on the synchronised level
module spi_edge_sync #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= rst ? {3{INIT}} : {s[1:0], d};
  assign rise = s[1] && !s[2];
  assign fall = !s[1] && s[2];
endmodule

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge: DEPTH x DATA_W memory shared by a host port, a burst SPI master and an oversampled SPI slave
module spi_mem_bridge
  import spi_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CLK_DIV = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              strans,
  input  logic              read_write_,
  input  logic [ADDR_W-1:0] madd,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] out,
  input  logic              m_go,
  input  logic [ADDR_W-1:0] m_base,
  input  logic [ADDR_W-1:0] m_len,
  output logic              busy,
  output logic              done,
  input  logic              miso,
  output logic              mosi,
  output logic              mclk,
  output logic              cs,
  input  logic              Mosi,
  input  logic              Mclk,
  input  logic              Cs,
  output logic              Miso,
  output logic              frame_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] B_WORD = BW'(DATA_W);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  function automatic logic head(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction
  function automatic logic [DATA_W-1:0] shl(input logic [DATA_W-1:0] w, input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0] mode;
  m_state_t st, nxt;
  logic [ADDR_W-1:0] addr, cnt, ptr;
  logic [DATA_W-1:0] tx, rx, stx, srx, s_rx;
  logic [DW-1:0] dcnt;
  logic [BW-1:0] bcnt, sbcnt;
  logic dlast, abort;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_s;
  logic in_frame, s_start, s_stop, s_run, s_wr;
  assign mode = {strans, enable};
  assign dlast = dcnt == D_LAST;
  assign abort = mode != MODE_MASTER;
  always_ff @(posedge clk) st <= rst ? M_IDLE : nxt;
  always_comb begin
    nxt = st;
    case (st)
      M_IDLE: nxt = (m_go && !abort) ? M_LOAD : M_IDLE;
      M_LOAD: nxt = abort ? M_END : M_LOW;
      M_LOW: nxt = abort ? M_END : dlast ? M_HIGH : M_LOW;
      M_HIGH: nxt = abort ? M_END : !dlast ? M_HIGH : bcnt == B_WORD ? M_STORE : M_LOW;
      M_STORE: nxt = (abort || cnt == '0) ? M_END : M_LOAD;
      default: nxt = M_IDLE;
    endcase
  end
  always_comb begin
    busy = st != M_IDLE;
    done = st == M_END;
    cs = st == M_IDLE || st == M_END;
    mclk = st == M_HIGH;
    mosi = (st == M_LOW || st == M_HIGH) && head(tx);
  end
  always_ff @(posedge clk) begin
    if (st == M_IDLE && nxt == M_LOAD) begin
      addr <= m_base;
      cnt <= m_len;
    end
    if (st == M_LOAD) begin
      tx <= mem[addr];
      bcnt <= '0;
    end
    dcnt <= ((st == M_LOW || st == M_HIGH) && !dlast) ? dcnt + 1'b1 : '0;
    if (st == M_LOW && nxt == M_HIGH) begin
      rx <= shl(rx, miso);
      bcnt <= bcnt + 1'b1;
    end
    if (st == M_HIGH && nxt == M_LOW) tx <= shl(tx, 1'b0);
    if (st == M_STORE && !abort) begin
      addr <= addr + 1'b1;
      cnt <= cnt - 1'b1;
    end
  end
  spi_edge_sync #(.INIT(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(Mclk), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.INIT(1'b1)) u_cs (.clk(clk), .rst(rst), .d(Cs), .rise(cs_rise), .fall(cs_fall));
  always_ff @(posedge clk) mosi_s <= rst ? 2'b00 : {mosi_s[0], Mosi};
  assign s_stop = in_frame && (cs_rise || mode != MODE_SLAVE);
  assign s_start = !in_frame && cs_fall && mode == MODE_SLAVE;
  assign s_run = in_frame && !s_stop;
  assign s_rx = shl(srx, mosi_s[1]);
  assign s_wr = s_run && sclk_rise && sbcnt == B_LAST;
  assign Miso = in_frame && head(stx);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      sbcnt <= '0;
      in_frame <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (s_start) begin
        in_frame <= 1'b1;
        sbcnt <= '0;
        stx <= mem[ptr];
      end
      if (s_stop) begin
        in_frame <= 1'b0;
        sbcnt <= '0;
        if (sbcnt != '0) frame_err <= 1'b1;
      end
      if (s_run && sclk_rise) begin
        srx <= s_rx;
        sbcnt <= s_wr ? '0 : sbcnt + 1'b1;
      end
      if (s_run && sclk_fall && sbcnt != '0) stx <= shl(stx, 1'b0);
      if (s_wr) begin
        ptr <= ptr + 1'b1;
        stx <= mem[ptr + 1'b1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (mode == MODE_HOST && !read_write_) mem[madd] <= data;
    if (st == M_STORE && !abort) mem[addr] <= rx;
    if (s_wr) mem[ptr] <= s_rx;
  end
  always_ff @(posedge clk) out <= rst ? '0 : (mode == MODE_HOST && read_write_) ? mem[madd] : out;
endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge: directed host, master, slave, abort and reset checks for spi_mem_bridge
module tb_spi_mem_bridge;
  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, strans = 1'b0, read_write_ = 1'b0;
  logic [2:0] madd = '0, m_base = '0, m_len = '0;
  logic [7:0] data = '0, out;
  logic m_go = 1'b0, busy, done, miso = 1'b0, mosi, mclk, cs;
  logic Mosi = 1'b0, Mclk = 1'b0, Cs = 1'b1, Miso, frame_err;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  spi_mem_bridge dut (
    .clk(clk), .rst(rst), .enable(enable), .strans(strans), .read_write_(read_write_),
    .madd(madd), .data(data), .out(out), .m_go(m_go), .m_base(m_base), .m_len(m_len),
    .busy(busy), .done(done), .miso(miso), .mosi(mosi), .mclk(mclk), .cs(cs),
    .Mosi(Mosi), .Mclk(Mclk), .Cs(Cs), .Miso(Miso), .frame_err(frame_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    {strans, enable} = 2'b01;
    read_write_ = 1'b0;
    madd = a;
    data = d;
    tick;
  endtask
  task automatic host_read(input logic [2:0] a, input logic [7:0] e);
    {strans, enable} = 2'b01;
    read_write_ = 1'b1;
    madd = a;
    tick;
    chk($sformatf("read_mem%0d", a), out, e);
  endtask
  task automatic run_burst(input logic [2:0] b, input logic [2:0] l, input logic mi,
                           output logic [31:0] bits, output int pulses, output int dones,
                           output logic cs_bad, output logic len_bad, output logic busy_after);
    logic pm;
    int hl;
    bits = '0;
    pulses = 0;
    dones = 0;
    cs_bad = 1'b0;
    len_bad = 1'b0;
    busy_after = 1'b1;
    pm = 1'b0;
    hl = 0;
    {strans, enable} = 2'b10;
    miso = mi;
    m_base = b;
    m_len = l;
    m_go = 1'b1;
    tick;
    m_go = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (mclk && !pm) begin
        bits = {bits[30:0], mosi};
        pulses++;
      end
      if (mclk) hl++;
      else begin
        if (pm && hl != 4) len_bad = 1'b1;
        hl = 0;
      end
      if (busy && !done && cs) cs_bad = 1'b1;
      if (done) begin
        dones++;
        tick;
        busy_after = busy;
        dones += int'(done);
        break;
      end
      pm = mclk;
      tick;
    end
  endtask
  task automatic slave_frame(input logic [7:0] wr, input int nbits, output logic [7:0] rd);
    rd = '0;
    Cs = 1'b0;
    repeat (6) tick;
    for (int i = 7; i > 7 - nbits; i--) begin
      Mosi = wr[i];
      Mclk = 1'b0;
      repeat (5) tick;
      rd[i] = Miso;
      Mclk = 1'b1;
      repeat (5) tick;
    end
    Mclk = 1'b0;
    repeat (5) tick;
    Cs = 1'b1;
    repeat (6) tick;
  endtask
  logic [31:0] bits;
  int pulses, dones;
  logic cs_bad, len_bad, busy_after, got;
  logic [7:0] rd;
  logic [7:0] init_words [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'h70};
  initial begin
    tick;
    tick;
    chk("rst_out", out, 8'h00);
    chk("rst_cs", cs, 1'b1);
    chk("rst_mclk", mclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_Miso", Miso, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    tick;
    for (int i = 0; i < 8; i++) host_write(3'(i), init_words[i]);
    for (int i = 0; i < 8; i++) host_read(3'(i), init_words[i]);
    m_go = 1'b1;
    tick;
    m_go = 1'b0;
    tick;
    chk("go_ignored_in_host", busy, 1'b0);
    run_burst(3'd0, 3'd2, 1'b1, bits, pulses, dones, cs_bad, len_bad, busy_after);
    chk("burst_mosi", bits[23:0], 24'h123456);
    chk("burst_pulses", pulses, 24);
    chk("burst_done_once", dones, 1);
    chk("burst_cs_low", cs_bad, 1'b0);
    chk("burst_mclk_high_width", len_bad, 1'b0);
    chk("burst_busy_after", busy_after, 1'b0);
    host_read(3'd0, 8'hff);
    host_read(3'd1, 8'hff);
    host_read(3'd2, 8'hff);
    host_read(3'd3, 8'h78);
    host_write(3'd0, 8'h12);
    host_write(3'd1, 8'h34);
    host_write(3'd2, 8'h56);
    {strans, enable} = 2'b11;
    tick;
    slave_frame(8'hcc, 8, rd);
    chk("slave_miso0", rd, 8'h12);
    slave_frame(8'h72, 8, rd);
    chk("slave_miso1", rd, 8'h34);
    slave_frame(8'hff, 8, rd);
    chk("slave_miso2", rd, 8'h56);
    chk("slave_no_err", frame_err, 1'b0);
    host_read(3'd0, 8'hcc);
    host_read(3'd1, 8'h72);
    host_read(3'd2, 8'hff);
    {strans, enable} = 2'b11;
    tick;
    slave_frame(8'he0, 3, rd);
    chk("partial_frame_err", frame_err, 1'b1);
    host_read(3'd3, 8'h78);
    {strans, enable} = 2'b11;
    tick;
    slave_frame(8'ha5, 8, rd);
    chk("slave_same_ptr_miso", rd, 8'h78);
    chk("frame_err_sticky", frame_err, 1'b1);
    host_read(3'd3, 8'ha5);
    host_read(3'd4, 8'h9a);
    run_burst(3'd6, 3'd3, 1'b0, bits, pulses, dones, cs_bad, len_bad, busy_after);
    chk("wrap_mosi", bits, 32'hde70cc72);
    chk("wrap_pulses", pulses, 32);
    chk("wrap_done_once", dones, 1);
    chk("wrap_busy_falls", busy_after, 1'b0);
    host_read(3'd5, 8'hbc);
    host_read(3'd6, 8'h00);
    host_read(3'd7, 8'h00);
    host_read(3'd0, 8'h00);
    host_read(3'd1, 8'h00);
    host_read(3'd2, 8'hff);
    {strans, enable} = 2'b10;
    miso = 1'b0;
    m_base = 3'd3;
    m_len = 3'd0;
    m_go = 1'b1;
    tick;
    m_go = 1'b0;
    repeat (15) tick;
    chk("abort_busy_mid", busy, 1'b1);
    {strans, enable} = 2'b00;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      tick;
      got = done;
    end
    chk("abort_done", got, 1'b1);
    tick;
    chk("abort_busy_after", busy, 1'b0);
    host_read(3'd3, 8'ha5);
    {strans, enable} = 2'b10;
    m_base = 3'd2;
    m_go = 1'b1;
    tick;
    m_go = 1'b0;
    repeat (12) tick;
    rst = 1'b1;
    tick;
    chk("midrst_cs", cs, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mclk", mclk, 1'b0);
    chk("midrst_mosi", mosi, 1'b0);
    chk("midrst_out", out, 8'h00);
    rst = 1'b0;
    tick;
    host_read(3'd2, 8'hff);
    host_read(3'd3, 8'ha5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
